// File: rtl/game_controller_pkg.sv
// Shared definitions for the game sequencer: state codes (also used by the
// player life/money block) and the widths of the player-facing buses.
package game_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_PLAY  = 4'd1,
    ST_PAUSE = 4'd2,
    ST_OVER  = 4'd3,
    ST_WIN   = 4'd4
  } game_state_t;

  localparam int LIFE_W  = 10;
  localparam int MONEY_W = 7;
  localparam int TIME_W  = 7;

  // Index width for an n-entry selector, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_controller_rr_arbiter.sv
// Round-robin merge of N request pulses into at most one registered
// grant pulse per clock. Each source owns a single pending flag; a request
// is served in the cycle it arrives when it wins, otherwise it waits in its
// flag. Requests arriving while the flag is set are dropped, except when the
// flag is being granted in that same cycle, in which case the flag stays set.
module rr_arbiter
  import game_controller_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic         grant_valid
);

  localparam int IW = idx_width(N);

  logic [N-1:0]  pend;
  logic [N-1:0]  req_en;
  logic [N-1:0]  eff;
  logic [N-1:0]  onehot;
  logic [N-1:0]  pend_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] gnt_idx;
  logic          gnt;

  // Pick the first candidate at or after the pointer, wrapping around
  always_comb begin
    req_en  = en ? req : '0;
    eff     = pend | req_en;
    gnt     = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    onehot  = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!gnt && en && eff[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt) onehot[gnt_idx] = 1'b1;
    pend_next = (eff & ~onehot) | (onehot & pend & req_en);
  end

  // Pending flags, rotating pointer and the one-cycle grant pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= '0;
      ptr         <= '0;
      grant_valid <= 1'b0;
    end else begin
      grant_valid <= gnt;
      if (clr) begin
        pend <= '0;
        ptr  <= '0;
      end else begin
        pend <= pend_next;
        if (gnt) ptr <= IW'((int'(gnt_idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Round sequencer: state machine, round countdown and two round-robin
// arbiters producing the damage and hit pulses for the player block.
// damage/hit are plain one-cycle pulses with no back-pressure: the player
// block must accept a pulse in the cycle it is high.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int N_SRC         = 4,
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int ROUND_SECONDS = 60,
  parameter int WIN_GAIN      = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic [N_SRC-1:0]   dmg_req,
  input  logic [N_SRC-1:0]   hit_req,
  input  logic [LIFE_W-1:0]  life,
  input  logic [MONEY_W-1:0] money,
  output logic [3:0]         state,
  output logic               damage,
  output logic               hit,
  output logic [TIME_W-1:0]  time_left
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  game_state_t        st;
  logic [PW-1:0]      presc;
  logic [MONEY_W-1:0] money_base;
  logic [TIME_W-1:0]  tl;
  logic               in_play;
  logic               dead;
  logic               won;
  logic               play_end;
  logic               round_clr;
  logic               presc_wrap;

  assign in_play    = (st == ST_PLAY);
  assign dead       = (life == '0);
  // Widened compare so a money drop below the base never looks like a gain
  assign won        = ({1'b0, money} >= ({1'b0, money_base} + 8'(WIN_GAIN)));
  assign play_end   = dead | won | (tl == '0);
  // Leaving PLAY for OVER/WIN wipes the arbiters; PAUSE keeps them frozen
  assign round_clr  = in_play & play_end;
  assign presc_wrap = (presc == PW'(TICKS_PER_SEC - 1));

  assign state      = st;
  assign time_left  = tl;

  // Round state machine with its countdown timer and money baseline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      tl         <= '0;
      presc      <= '0;
      money_base <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            st         <= ST_PLAY;
            tl         <= TIME_W'(ROUND_SECONDS);
            presc      <= '0;
            money_base <= money;
          end
        end
        ST_PLAY: begin
          if (presc_wrap) begin
            presc <= '0;
            if (tl != '0) tl <= tl - TIME_W'(1);
          end else begin
            presc <= presc + PW'(1);
          end
          if (dead)             st <= ST_OVER;
          else if (won)         st <= ST_WIN;
          else if (tl == '0)    st <= ST_OVER;
          else if (pause)       st <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (pause) st <= ST_PLAY;
        end
        ST_OVER, ST_WIN: begin
          if (start) begin
            st <= ST_IDLE;
            tl <= '0;
          end
        end
        default: begin
          st <= ST_IDLE;
          tl <= '0;
        end
      endcase
    end
  end

  rr_arbiter #(.N(N_SRC)) u_dmg_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (in_play),
    .clr         (round_clr),
    .req         (dmg_req),
    .grant_valid (damage)
  );

  rr_arbiter #(.N(N_SRC)) u_hit_arb (
    .clk         (clk),
    .rst         (rst),
    .en          (in_play),
    .clr         (round_clr),
    .req         (hit_req),
    .grant_valid (hit)
  );

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: table of FSM/timer vectors, hand sequences for
// arbitration, game over, win, pause and mid-round reset, and randomized
// traffic checked cycle by cycle against a rule-level reference model.
module tb_game_controller;

  localparam int N_SRC = 4;
  localparam int TPS   = 4;
  localparam int RS    = 3;
  localparam int WG    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] dmg_req = '0;
  logic [3:0] hit_req = '0;
  logic [9:0] life = '1;
  logic [6:0] money = '0;
  logic [3:0] state;
  logic       damage;
  logic       hit;
  logic [6:0] time_left;

  int checks = 0;
  int failures = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  game_controller #(
    .N_SRC(N_SRC), .TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS), .WIN_GAIN(WG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .dmg_req(dmg_req), .hit_req(hit_req), .life(life), .money(money),
    .state(state), .damage(damage), .hit(hit), .time_left(time_left)
  );

  // ---------------- reference model ----------------
  int  m_state, m_tl, m_presc, m_base;
  bit  m_pend[2][4];
  int  m_ptr[2];
  bit  m_pulse[2];
  bit  player_en = 1'b0;
  logic [12:0] exp_q[$];

  task automatic model_reset();
    m_state = 0; m_tl = 0; m_presc = 0; m_base = 0;
    for (int a = 0; a < 2; a++) begin
      m_ptr[a] = 0; m_pulse[a] = 1'b0;
      for (int i = 0; i < 4; i++) m_pend[a][i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // One arbitration round for arbiter a; returns 1 when a grant is issued
  function automatic bit arb_model(input int a, input logic [3:0] req,
                                   input bit live, input bit wipe);
    bit want[4];
    int g;
    g = -1;
    if (!live) return 1'b0;
    for (int i = 0; i < 4; i++) want[i] = m_pend[a][i] | req[i];
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr[a] + k) % 4;
      if (g < 0 && want[j]) g = j;
    end
    for (int i = 0; i < 4; i++)
      m_pend[a][i] = (i == g) ? (m_pend[a][i] & req[i]) : want[i];
    if (g >= 0) m_ptr[a] = (g + 1) % 4;
    if (wipe) begin
      for (int i = 0; i < 4; i++) m_pend[a][i] = 1'b0;
      m_ptr[a] = 0;
    end
    return (g >= 0);
  endfunction

  // Apply the game rules to the current inputs and queue the expected outputs
  task automatic model_step();
    int ns, ntl, npre, nbase;
    bit wipe, live;
    ns = m_state; ntl = m_tl; npre = m_presc; nbase = m_base;
    live = (m_state == 1);
    case (m_state)
      0: if (start) begin ns = 1; ntl = RS; npre = 0; nbase = int'(money); end
      1: begin
        if (m_presc == TPS - 1) begin
          npre = 0;
          if (m_tl > 0) ntl = m_tl - 1;
        end else npre = m_presc + 1;
        if (life == 0)                      ns = 3;
        else if (int'(money) - m_base >= WG) ns = 4;
        else if (m_tl == 0)                 ns = 3;
        else if (pause)                     ns = 2;
      end
      2: if (pause) ns = 1;
      default: if (start) begin ns = 0; ntl = 0; end
    endcase
    wipe = live && (ns == 3 || ns == 4);
    m_pulse[0] = arb_model(0, dmg_req, live, wipe);
    m_pulse[1] = arb_model(1, hit_req, live, wipe);
    m_state = ns; m_tl = ntl; m_presc = npre; m_base = nbase;
    exp_q.push_back({4'(ns), 7'(ntl), m_pulse[0], m_pulse[1]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: model step, edge, scoreboard compare, player life update
  task automatic tick();
    logic [12:0] got, exp;
    bit drop;
    drop = player_en && m_pulse[0];
    model_step();
    @(posedge clk);
    #1;
    got = {state, time_left, damage, hit};
    exp = exp_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL model_cycle t=%0t got st=%0d tl=%0d d=%0b h=%0b want st=%0d tl=%0d d=%0b h=%0b",
               $time, got[12:9], got[8:2], got[1], got[0],
               exp[12:9], exp[8:2], exp[1], exp[0]);
    end
    if (drop) life = life >> 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    dmg_req = '0; hit_req = '0; life = '1; money = '0; player_en = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_state", int'(state), 0);
    chk("reset_time_left", int'(time_left), 0);
    chk("reset_damage", int'(damage), 0);
    chk("reset_hit", int'(hit), 0);
    model_reset();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       start;
    logic       pause;
    logic [3:0] exp_state;
    logic [6:0] exp_tl;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [7:0] seq;
    int cnt, hits;
    bit held;

    // Timeout path: IDLE -> PLAY(3) -> countdown every 4 cycles -> OVER -> IDLE
    tbl[0]  = '{1'b0, 1'b0, 4'd0, 7'd0};
    tbl[1]  = '{1'b0, 1'b1, 4'd0, 7'd0};
    tbl[2]  = '{1'b1, 1'b0, 4'd1, 7'd3};
    tbl[3]  = '{1'b0, 1'b0, 4'd1, 7'd3};
    tbl[4]  = '{1'b0, 1'b0, 4'd1, 7'd3};
    tbl[5]  = '{1'b0, 1'b0, 4'd1, 7'd3};
    tbl[6]  = '{1'b0, 1'b0, 4'd1, 7'd2};
    tbl[7]  = '{1'b1, 1'b0, 4'd1, 7'd2};
    tbl[8]  = '{1'b0, 1'b0, 4'd1, 7'd2};
    tbl[9]  = '{1'b0, 1'b0, 4'd1, 7'd2};
    tbl[10] = '{1'b0, 1'b0, 4'd1, 7'd1};
    tbl[11] = '{1'b0, 1'b0, 4'd1, 7'd1};
    tbl[12] = '{1'b0, 1'b0, 4'd1, 7'd1};
    tbl[13] = '{1'b0, 1'b0, 4'd1, 7'd1};
    tbl[14] = '{1'b0, 1'b0, 4'd1, 7'd0};
    tbl[15] = '{1'b0, 1'b0, 4'd3, 7'd0};
    tbl[16] = '{1'b0, 1'b1, 4'd3, 7'd0};
    tbl[17] = '{1'b1, 1'b0, 4'd0, 7'd0};
    tbl[18] = '{1'b1, 1'b0, 4'd1, 7'd3};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      start = tbl[i].start;
      pause = tbl[i].pause;
      tick();
      chk($sformatf("tbl%0d_state", i), int'(state), int'(tbl[i].exp_state));
      chk($sformatf("tbl%0d_time", i), int'(time_left), int'(tbl[i].exp_tl));
    end
    start = 1'b0; pause = 1'b0;

    // Arbitration burst: 1111 then a repeat on source 0 -> five back-to-back pulses
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    seq = '0;
    dmg_req = 4'hF; tick(); seq[0] = damage;
    dmg_req = 4'h1; tick(); seq[1] = damage;
    dmg_req = 4'h0;
    for (int i = 2; i < 8; i++) begin
      tick();
      seq[i] = damage;
    end
    chk("arb_burst_pulses", int'(seq), 8'h1F);

    // Ten damage grants drain life; simultaneous win condition still gives OVER
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    player_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      dmg_req = 4'(1 << (k % 4));
      tick();
    end
    dmg_req = '0;
    tick();
    chk("life_low_still_play", int'(state), 1);
    money = 7'd5;
    tick();
    chk("life_zero_over", int'(state), 3);
    player_en = 1'b0;
    money = '0;

    // Win threshold relative to the money latched at round start
    do_reset();
    money = 7'd20;
    start = 1'b1; tick(); start = 1'b0;
    money = 7'd24;
    for (int i = 0; i < 3; i++) tick();
    chk("money24_play", int'(state), 1);
    money = 7'd25;
    tick();
    chk("money25_win", int'(state), 4);
    start = 1'b1; tick(); start = 1'b0;
    chk("win_to_idle", int'(state), 0);
    money = '0;

    // Pause freezes the timer and drops hit requests
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pause_tl_before", int'(time_left), 2);
    pause = 1'b1; tick(); pause = 1'b0;
    chk("pause_enter", int'(state), 2);
    held = 1'b1; hits = 0;
    hit_req = 4'hF; tick(); hit_req = '0;
    hits += int'(hit);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (time_left != 7'd2 || state != 4'd2) held = 1'b0;
      hits += int'(hit);
    end
    chk("pause_held", int'(held), 1);
    pause = 1'b1; tick(); pause = 1'b0;
    chk("resume_state", int'(state), 1);
    chk("resume_tl", int'(time_left), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      hits += int'(hit);
    end
    chk("resume_countdown", int'(time_left), 1);
    chk("pause_hit_dropped", hits, 0);

    // Asynchronous reset with two damage flags pending
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    dmg_req = 4'b0111; tick(); dmg_req = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_damage", int'(damage), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(damage);
    end
    chk("post_rst_no_damage", cnt, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      start   = ($urandom_range(0, 15) == 0);
      pause   = ($urandom_range(0, 20) == 0);
      dmg_req = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      hit_req = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      if ($urandom_range(0, 7) == 0) money = 7'($urandom_range(0, 99));
      life = ($urandom_range(0, 40) == 0) ? 10'h000 : 10'h3FF;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer. Drives the 4-bit `state` bus and the single-cycle `damage`/`hit` pulses consumed by the player life/money block, and watches its `life` and `money` outputs. It contains the round state machine, a round countdown timer, and two round-robin arbiters. The arbiters merge per-source damage and hit requests from enemy/projectile logic into at most one pulse per clock each.

## Interface
Parameters:
- `N_SRC`, 4: number of damage/hit requesters.
- `TICKS_PER_SEC`, 100_000_000: clk cycles per timer second.
- `ROUND_SECONDS`, 60: round length in seconds, at most 99.
- `WIN_GAIN`, 30: money gained within one round that wins it.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: single-cycle pulse, already debounced.
- `pause` in 1: single-cycle pulse, already debounced.
- `dmg_req` in N_SRC: per-source damage request pulses.
- `hit_req` in N_SRC: per-source hit request pulses.
- `life` in 10: thermometer life bar from the player block.
- `money` in 7: player money, 0..99.
- `state` out 4: game state code.
- `damage` out 1: registered one-cycle damage pulse.
- `hit` out 1: registered one-cycle hit pulse.
- `time_left` out 7: remaining round seconds.

## Operation
State codes (`state`):
- IDLE=0
- PLAY=1
- PAUSE=2
- OVER=3
- WIN=4

Transitions, evaluated once per clock:
- IDLE, `start` → PLAY.
  - Load `time_left`=ROUND_SECONDS.
  - Clear the prescaler.
  - Latch `money_base`=`money`.
- PLAY, in priority order:
  1. `life`==0 → OVER.
  2. `money`-`money_base` ≥ WIN_GAIN → WIN.
  3. `time_left`==0 → OVER.
  4. `pause` → PAUSE.
- PAUSE, `pause` → PLAY. Timer and pending flags are frozen.
- OVER or WIN, `start` → IDLE.
- `start` in PLAY or PAUSE is ignored. `pause` outside PLAY or PAUSE is ignored.

Timer:
- The prescaler counts 0..TICKS_PER_SEC-1 in PLAY only.
- On wrap with `time_left`>0, `time_left` decrements by 1.
- `time_left` holds its value in PAUSE, OVER and WIN, and is 0 in IDLE.

Arbitration. Damage and hit are identical and independent:
- Each source has one pending flag, set by its request only while in PLAY.
- A request while the flag is already set is dropped. Flags do not count.
- Each cycle in PLAY, grant the lowest-index pending source at or after the round-robin pointer.
- On a grant: clear that source's flag, advance the pointer to grant+1 (mod N_SRC), and drive the output pulse the next cycle.
- A request and a grant for the same source in the same cycle leave the flag set.
- All flags clear, and pointers reset to 0, on any transition out of PLAY other than to PAUSE.
- No grants occur in PAUSE.
- `money` saturates at 99, so a round whose `money_base` exceeds 99-WIN_GAIN cannot be won. This is accepted behaviour.

## Timing
- Reset values: `state`=0, `damage`=0, `hit`=0, `time_left`=0. Flags, pointers, prescaler and `money_base` reset to 0.
- `state` changes on the clock edge after the qualifying input.
- A request in cycle t gives a pulse on the output at t+1 at the earliest.
- Worst-case latency is N_SRC cycles when all sources are pending.
- `damage` and `hit` may be high in the same cycle.
- The player block sees life drop one cycle after `damage`. OVER is entered one cycle after that.
- Reset mid-round forces IDLE immediately and asynchronously. Pending pulses are lost.

## Structure
- Shared package holds the state code constants (IDLE..WIN, 4-bit). The player block uses the same codes.
- Sub-module `rr_arbiter`, parameter N: request pulses in, pending flags, pointer, registered one-cycle grant-valid out. Instantiate it twice, once for damage and once for hit, with an enable tied to state==PLAY and a clear tied to leaving PLAY for anything but PAUSE.

## Test plan
Bench parameters: N_SRC=4, TICKS_PER_SEC=4, ROUND_SECONDS=3, WIN_GAIN=5.
- Timeout: `start` in IDLE → PLAY with `time_left`=3. It decrements every 4 cycles and reaches 0 after 12 cycles. OVER follows the next cycle. `start` then returns to IDLE with `time_left`=0.
- Arbitration order: `dmg_req`=4'b1111 in one cycle → exactly 4 `damage` pulses on 4 consecutive cycles. Grant order is 0,1,2,3. A repeat request on source 0 during the burst is queued and granted 5th.
- Damage to game over: 10 single `damage` grants with a player model in the loop → `life`=0 → OVER. A simultaneous money win condition still yields OVER.
- Win: `money_base`=20, and `money` reaching 25 → WIN on the next edge. `money` at 24 stays in PLAY.
- Pause: `pause` at `time_left`=2 → PAUSE. `hit_req` in PAUSE is dropped. `time_left` stays 2 for 20 cycles. A second `pause` resumes the countdown from 2.
- Reset mid-round: `rst` while 2 flags are pending → `state`=0 and no `damage` pulse afterwards.
